// File: rtl/knl_frame_deserializer.sv
// knl_frame_deserializer: packs the begP/endP-delimited serial payload MSB-first into
// WORD_W-bit words and hands them out through a single-entry valid/ready register.
// The final word of a frame is tagged with word_last. Overrun and over-length frames
// are aborted with a frame_err pulse and dropped.
// Optional build macro KNL_DESER_STATS_EN adds saturating frame_cnt/err_cnt/beg_cnt outputs.
module knl_frame_deserializer #(
  parameter int WORD_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dataIn,
  input  logic                        begP,
  input  logic                        endP,
  output logic [WORD_W-1:0]           word_data,
  output logic [$clog2(WORD_W+1)-1:0] word_bits,
  output logic                        word_last,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        frame_err,
  output logic                        busy
`ifdef KNL_DESER_STATS_EN
  ,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 err_cnt,
  output logic [15:0]                 beg_cnt
`endif
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [BW-1:0] FULL_BITS = BW'(WORD_W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} stateT;

  stateT             stateReg, stateNext;
  logic [WORD_W-1:0] srReg, srNext;
  logic [BW-1:0]     bitCntReg, bitCntNext;
  logic [CW-1:0]     wordCntReg, wordCntNext;

  logic [WORD_W-1:0] shiftedIn;
  logic              push, pushLast, abort, overrun, load;
  logic [WORD_W-1:0] pushData;
  logic [BW-1:0]     pushBits;

  assign shiftedIn = {srReg[WORD_W-2:0], dataIn};
  assign busy      = (stateReg != IDLE);

  // Next-state and push decision; the endP/begP cycle itself never carries payload.
  always_comb begin
    stateNext   = stateReg;
    srNext      = srReg;
    bitCntNext  = bitCntReg;
    wordCntNext = wordCntReg;
    push        = 1'b0;
    pushLast    = 1'b0;
    pushData    = '0;
    pushBits    = '0;
    abort       = 1'b0;
    overrun     = 1'b0;
    load        = 1'b0;
    case (stateReg)
      IDLE: begin
        if (begP) begin
          stateNext   = COLLECT;
          bitCntNext  = '0;
          wordCntNext = '0;
        end
      end
      COLLECT: begin
        if (endP) begin
          // Close the frame: remaining bits left-aligned, zero bits gives a marker word.
          push        = 1'b1;
          pushLast    = 1'b1;
          pushBits    = bitCntReg;
          pushData    = srReg << (FULL_BITS - bitCntReg);
          bitCntNext  = '0;
          wordCntNext = '0;
          stateNext   = begP ? COLLECT : IDLE;
        end else if (begP) begin
          // A new start marker inside a frame kills the old frame and restarts.
          abort       = 1'b1;
          bitCntNext  = '0;
          wordCntNext = '0;
        end else if (wordCntReg == MAX_CNT) begin
          abort     = 1'b1;
          stateNext = DISCARD;
        end else begin
          srNext = shiftedIn;
          if (bitCntReg == LAST_BIT) begin
            push        = 1'b1;
            pushBits    = FULL_BITS;
            pushData    = shiftedIn;
            bitCntNext  = '0;
            wordCntNext = wordCntReg + 1'b1;
          end else begin
            bitCntNext = bitCntReg + 1'b1;
          end
        end
      end
      default: begin
        if (endP) begin
          stateNext   = begP ? COLLECT : IDLE;
          bitCntNext  = '0;
          wordCntNext = '0;
        end
      end
    endcase
    // A push into an occupied, stalled register is an overrun. A closing word that
    // overruns has already ended its frame, so there is nothing left to discard.
    overrun = push && word_valid && !word_ready;
    load    = push && !overrun;
    if (overrun) begin
      abort = 1'b1;
      if (!pushLast) stateNext = DISCARD;
    end
  end

  // FSM and shift/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      srReg      <= '0;
      bitCntReg  <= '0;
      wordCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      srReg      <= srNext;
      bitCntReg  <= bitCntNext;
      wordCntReg <= wordCntNext;
    end
  end

  // Single-entry output register: load on push, hold until valid&ready, error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_data  <= '0;
      word_bits  <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= abort;
      if (load) begin
        word_data  <= pushData;
        word_bits  <= pushBits;
        word_last  <= pushLast;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef KNL_DESER_STATS_EN
  // Saturating event counters for in-hardware detection-rate measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      beg_cnt   <= '0;
    end else begin
      if (load && pushLast && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (abort && err_cnt != 16'hFFFF)              err_cnt   <= err_cnt + 16'd1;
      if (begP && beg_cnt != 16'hFFFF)               beg_cnt   <= beg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_knl_frame_deserializer.sv
// Testbench for knl_frame_deserializer: directed scenarios followed by random traffic,
// all compared cycle by cycle against a frame-level model built on a bit queue.
`timescale 1ns/1ps
module tb_knl_frame_deserializer;

  localparam int W    = 8;
  localparam int MAXW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         dataIn, begP, endP, word_ready;
  logic [W-1:0] word_data;
  logic [3:0]   word_bits;
  logic         word_last, word_valid, frame_err, busy;
`ifdef KNL_DESER_STATS_EN
  logic [15:0]  frame_cnt, err_cnt, beg_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knl_frame_deserializer #(.WORD_W(W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .begP(begP), .endP(endP),
    .word_data(word_data), .word_bits(word_bits), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .frame_err(frame_err),
    .busy(busy)
`ifdef KNL_DESER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt), .beg_cnt(beg_cnt)
`endif
  );

  // Reference model: frame mode, queue of payload bits for the word being built,
  // words completed in this frame, and the expected content of the output register.
  typedef enum int {M_IDLE, M_COLLECT, M_DISCARD} modeT;
  modeT         mMode;
  bit           partial[$];
  int           mWords;
  bit           mValid, mLast, mErr;
  logic [W-1:0] mData;
  int           mBits;
  int           mFrames, mErrs, mBegs;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic packPartial(output logic [W-1:0] d, output int n);
    d = '0;
    n = partial.size();
    for (int i = 0; i < n; i++) d[W-1-i] = partial[i];
  endtask

  task automatic modelReset();
    mMode = M_IDLE; partial.delete(); mWords = 0;
    mValid = 0; mLast = 0; mErr = 0; mData = '0; mBits = 0;
    mFrames = 0; mErrs = 0; mBegs = 0;
  endtask

  task automatic modelStep(input bit b, input bit e, input bit d, input bit r);
    bit push, last, err;
    logic [W-1:0] pd;
    int pb;
    push = 0; last = 0; err = 0; pd = '0; pb = 0;
    case (mMode)
      M_IDLE: if (b) begin mMode = M_COLLECT; partial.delete(); mWords = 0; end
      M_COLLECT: begin
        if (e) begin
          push = 1; last = 1; packPartial(pd, pb);
          partial.delete(); mWords = 0;
          mMode = b ? M_COLLECT : M_IDLE;
        end else if (b) begin
          err = 1; partial.delete(); mWords = 0;
        end else if (mWords == MAXW) begin
          err = 1; mMode = M_DISCARD;
        end else begin
          partial.push_back(d);
          if (partial.size() == W) begin
            push = 1; packPartial(pd, pb); partial.delete(); mWords++;
          end
        end
      end
      default: if (e) begin mMode = b ? M_COLLECT : M_IDLE; partial.delete(); mWords = 0; end
    endcase
    if (push) begin
      if (mValid && !r) begin
        err = 1;
        if (!last) mMode = M_DISCARD;
      end else begin
        mData = pd; mBits = pb; mLast = last; mValid = 1;
        if (last && mFrames < 65535) mFrames++;
      end
    end else if (mValid && r) begin
      mValid = 0;
    end
    mErr = err;
    if (err && mErrs < 65535) mErrs++;
    if (b && mBegs < 65535) mBegs++;
  endtask

  task automatic compareAll();
    checkEq("valid", 32'(word_valid), 32'(mValid));
    if (mValid) begin
      checkEq("data", 32'(word_data), 32'(mData));
      checkEq("bits", 32'(word_bits), 32'(mBits));
      checkEq("last", 32'(word_last), 32'(mLast));
    end
    checkEq("frame_err", 32'(frame_err), 32'(mErr));
    checkEq("busy", 32'(busy), 32'(mMode != M_IDLE));
`ifdef KNL_DESER_STATS_EN
    checkEq("frame_cnt", 32'(frame_cnt), 32'(mFrames));
    checkEq("err_cnt", 32'(err_cnt), 32'(mErrs));
    checkEq("beg_cnt", 32'(beg_cnt), 32'(mBegs));
`endif
  endtask

  task automatic cycle(input bit b, input bit e, input bit d, input bit r);
    begP = b; endP = e; dataIn = d; word_ready = r;
    if (word_valid && word_ready)
      $display("word accepted: data=%02h bits=%0d last=%0d", word_data, word_bits, word_last);
    modelStep(b, e, d, r);
    @(posedge clk); #1;
    compareAll();
  endtask

  task automatic sendBits(input logic [31:0] v, input int n, input bit r);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, v[i], r);
  endtask

  task automatic checkWord(input string tag, input logic [W-1:0] d, input int n, input bit l);
    checkEq({tag, "_valid"}, 32'(word_valid), 32'd1);
    checkEq({tag, "_data"}, 32'(word_data), 32'(d));
    checkEq({tag, "_bits"}, 32'(word_bits), 32'(n));
    checkEq({tag, "_last"}, 32'(word_last), 32'(l));
  endtask

  task automatic checkCleared(input string tag);
    checkEq({tag, "_valid"}, 32'(word_valid), 32'd0);
    checkEq({tag, "_data"}, 32'(word_data), 32'd0);
    checkEq({tag, "_bits"}, 32'(word_bits), 32'd0);
    checkEq({tag, "_last"}, 32'(word_last), 32'd0);
    checkEq({tag, "_err"}, 32'(frame_err), 32'd0);
    checkEq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; dataIn = 0; begP = 0; endP = 0; word_ready = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkCleared("reset");
    reset = 1'b0;

    // Idle line: no frame start, nothing happens.
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'($urandom), 1'b1);
    checkEq("idle_valid", 32'(word_valid), 32'd0);
    checkEq("idle_busy", 32'(busy), 32'd0);

    // Full word followed by an empty closing marker.
    cycle(1, 0, 0, 1);
    sendBits(32'hB2, 8, 1);
    checkWord("t2_word", 8'hB2, 8, 0);
    cycle(0, 1, 0, 1);
    checkWord("t2_marker", 8'h00, 0, 1);
    cycle(0, 0, 0, 1);

    // Short frame, left-aligned partial word.
    cycle(1, 0, 0, 1);
    sendBits(32'b111, 3, 1);
    cycle(0, 1, 0, 1);
    checkWord("t3_word", 8'hE0, 3, 1);
    cycle(0, 0, 0, 1);

    // Overrun with a stalled consumer: held word survives, frame discarded.
    cycle(1, 0, 0, 0);
    sendBits(32'hC3, 8, 0);
    sendBits(32'h5A, 8, 0);
    checkEq("t4_err", 32'(frame_err), 32'd1);
    checkWord("t4_held", 8'hC3, 8, 0);
    sendBits(32'h1, 1, 0);
    checkEq("t4_err_pulse", 32'(frame_err), 32'd0);
    checkEq("t4_discard", 32'(busy), 32'd1);
    cycle(0, 1, 0, 0);
    checkWord("t4_after", 8'hC3, 8, 0);
    checkEq("t4_idle", 32'(busy), 32'd0);
    cycle(0, 0, 0, 1);

    // Length limit: bit after MAXW full words aborts, no closing word.
    cycle(1, 0, 0, 1);
    sendBits(32'hA5, 8, 1);
    sendBits(32'h3C, 8, 1);
    checkWord("t5_word2", 8'h3C, 8, 0);
    sendBits(32'h1, 1, 1);
    checkEq("t5_err", 32'(frame_err), 32'd1);
    cycle(0, 1, 0, 1);
    checkEq("t5_nolast", 32'(word_valid), 32'd0);
    checkEq("t5_idle", 32'(busy), 32'd0);

    // Back-to-back frames: endP and begP in the same cycle.
    cycle(1, 0, 0, 1);
    sendBits(32'b1010, 4, 1);
    cycle(1, 1, 0, 1);
    checkWord("t6_word", 8'hA0, 4, 1);
    checkEq("t6_busy", 32'(busy), 32'd1);
    sendBits(32'h69, 8, 1);
    checkWord("t6_next", 8'h69, 8, 0);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);

    // Asynchronous reset in the middle of a frame with a word pending.
    cycle(1, 0, 0, 0);
    sendBits(32'h7E, 8, 0);
    sendBits(32'b101, 3, 0);
    reset = 1'b1;
    #2;
    modelReset();
    checkCleared("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    compareAll();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
